// File: rtl/board_cell_picker.sv
// board_cell_picker
// Turns a left-button click at screen coordinates into a board cell address
// (row, column, box index, cell value) using the centred grid geometry that
// the board overlay draws. Division by the box size is iterative and runs for
// a fixed number of cycles, so a hit always has the same latency.
module board_cell_picker #(
    parameter int SCREEN_WIDTH  = 1024,
    parameter int SCREEN_HEIGHT = 768,
    parameter int CELL_PX       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      is_game_on,
    input  logic [2:0]                board_size,
    input  logic [15:0][15:0][4:0]    board,
    input  logic [11:0]               mouse_xpos,
    input  logic [11:0]               mouse_ypos,
    input  logic                      mouse_left,
    output logic                      busy,
    output logic                      pick_valid,
    output logic                      pick_miss,
    output logic [3:0]                pick_row,
    output logic [3:0]                pick_col,
    output logic [3:0]                pick_box,
    output logic [4:0]                pick_value
);

    localparam int CELL_SHIFT = $clog2(CELL_PX);
    // Worst-case quotient is 15/2 = 7, so seven subtract steps always suffice.
    localparam logic [2:0] DIV_LAST = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        DIV   = 3'd2,
        BOX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_reg, state_next;

    logic        prev_left_reg;
    logic        held_reg;
    logic        click;

    logic [11:0] x_reg, y_reg;
    logic [2:0]  size_reg;
    logic [3:0]  row_reg, col_reg;
    logic [3:0]  rem_r_reg, rem_c_reg;
    logic [3:0]  quo_r_reg, quo_c_reg;
    logic [2:0]  div_cnt_reg;

    logic        miss_out_reg;
    logic [3:0]  row_out_reg, col_out_reg, box_out_reg;
    logic [4:0]  value_out_reg;

    // Geometry of the centred board for the latched size.
    logic [15:0] n_cells, span, x0, y0, x16, y16, dx, dy;
    logic        size_ok, hit;
    logic [3:0]  row_calc, col_calc;
    logic [3:0]  size4;
    logic [7:0]  box_full;

    // A click is a rising edge of the button; a button held through reset
    // stays masked until it has been seen released.
    assign click = mouse_left & ~prev_left_reg & ~held_reg;

    // Hit test and cell coordinates, all in 16-bit arithmetic.
    always_comb begin
        size4    = {1'b0, size_reg};
        n_cells  = 16'(size_reg) * 16'(size_reg);
        span     = n_cells << CELL_SHIFT;
        x0       = (16'(SCREEN_WIDTH) - span) >> 1;
        y0       = (16'(SCREEN_HEIGHT) - span) >> 1;
        x16      = {4'b0, x_reg};
        y16      = {4'b0, y_reg};
        dx       = x16 - x0;
        dy       = y16 - y0;
        col_calc = 4'(dx >> CELL_SHIFT);
        row_calc = 4'(dy >> CELL_SHIFT);
        size_ok  = (size_reg >= 3'd2) && (size_reg <= 3'd4);
        hit      = size_ok
                   && (x16 >= x0) && (x16 < x0 + span)
                   && (y16 >= y0) && (y16 < y0 + span);
        box_full = 8'(quo_r_reg) * 8'(size4) + 8'(quo_c_reg);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and status outputs; losing is_game_on aborts silently.
    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        pick_valid = (state_reg == DONE);
        case (state_reg)
            IDLE: begin
                if (click && is_game_on) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!is_game_on) begin
                    state_next = IDLE;
                end else if (hit) begin
                    state_next = DIV;
                end else begin
                    state_next = DONE;
                end
            end
            DIV: begin
                if (!is_game_on) begin
                    state_next = IDLE;
                end else if (div_cnt_reg == DIV_LAST) begin
                    state_next = BOX;
                end
            end
            BOX: begin
                if (!is_game_on) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: click capture, dividers, and result registers that only
    // change when a pick actually completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_left_reg <= 1'b0;
            held_reg      <= mouse_left;
            x_reg         <= '0;
            y_reg         <= '0;
            size_reg      <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            rem_r_reg     <= '0;
            rem_c_reg     <= '0;
            quo_r_reg     <= '0;
            quo_c_reg     <= '0;
            div_cnt_reg   <= '0;
            miss_out_reg  <= 1'b0;
            row_out_reg   <= '0;
            col_out_reg   <= '0;
            box_out_reg   <= '0;
            value_out_reg <= '0;
        end else begin
            prev_left_reg <= mouse_left;
            if (!mouse_left) begin
                held_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (click && is_game_on) begin
                        x_reg    <= mouse_xpos;
                        y_reg    <= mouse_ypos;
                        size_reg <= board_size;
                    end
                end
                CHECK: begin
                    row_reg     <= row_calc;
                    col_reg     <= col_calc;
                    rem_r_reg   <= row_calc;
                    rem_c_reg   <= col_calc;
                    quo_r_reg   <= '0;
                    quo_c_reg   <= '0;
                    div_cnt_reg <= '0;
                    if (state_next == DONE) begin
                        miss_out_reg  <= 1'b1;
                        row_out_reg   <= '0;
                        col_out_reg   <= '0;
                        box_out_reg   <= '0;
                        value_out_reg <= '0;
                    end
                end
                DIV: begin
                    div_cnt_reg <= div_cnt_reg + 3'd1;
                    if (rem_r_reg >= size4) begin
                        rem_r_reg <= rem_r_reg - size4;
                        quo_r_reg <= quo_r_reg + 4'd1;
                    end
                    if (rem_c_reg >= size4) begin
                        rem_c_reg <= rem_c_reg - size4;
                        quo_c_reg <= quo_c_reg + 4'd1;
                    end
                end
                BOX: begin
                    if (state_next == DONE) begin
                        miss_out_reg  <= 1'b0;
                        row_out_reg   <= row_reg;
                        col_out_reg   <= col_reg;
                        box_out_reg   <= 4'(box_full);
                        value_out_reg <= board[row_reg][col_reg];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pick_miss  = miss_out_reg;
    assign pick_row   = row_out_reg;
    assign pick_col   = col_out_reg;
    assign pick_box   = box_out_reg;
    assign pick_value = value_out_reg;

endmodule

// File: tb/tb_board_cell_picker.sv
// Directed bench for board_cell_picker: hit/miss geometry, latency, click
// edge handling, abort and reset behaviour.
module tb_board_cell_picker;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   is_game_on;
    logic [2:0]             board_size;
    logic [15:0][15:0][4:0] board;
    logic [11:0]            mouse_xpos;
    logic [11:0]            mouse_ypos;
    logic                   mouse_left;
    logic                   busy;
    logic                   pick_valid;
    logic                   pick_miss;
    logic [3:0]             pick_row;
    logic [3:0]             pick_col;
    logic [3:0]             pick_box;
    logic [4:0]             pick_value;

    int tests_run = 0;
    int tests_failed = 0;

    board_cell_picker dut (
        .clk        (clk),
        .rst        (rst),
        .is_game_on (is_game_on),
        .board_size (board_size),
        .board      (board),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .busy       (busy),
        .pick_valid (pick_valid),
        .pick_miss  (pick_miss),
        .pick_row   (pick_row),
        .pick_col   (pick_col),
        .pick_box   (pick_box),
        .pick_value (pick_value)
    );

    always #5 clk = ~clk;

    function automatic int cell_val(input int r, input int c);
        return (r * 3 + c * 5 + 1) % 32;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Press at (x,y) with the given size, wait (bounded) for pick_valid,
    // then release. lat = cycles from the sampling cycle, -1 on timeout.
    task automatic do_pick(input int x, input int y, input int sz, output int lat);
        @(negedge clk);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        board_size = 3'(sz);
        mouse_left = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (pick_valid) begin
                lat = i;
                break;
            end
        end
        $display("[TB] pick x=%0d y=%0d size=%0d lat=%0d miss=%0d row=%0d col=%0d box=%0d value=%0d",
                 x, y, sz, lat, pick_miss, pick_row, pick_col, pick_box, pick_value);
        @(negedge clk);
        mouse_left = 1'b0;
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (pick_valid) n++;
        end
    endtask

    task automatic hit_test(input string tag, input int x, input int y, input int sz,
                            input int r, input int c, input int b);
        int lat;
        do_pick(x, y, sz, lat);
        check_eq({tag, "_lat"}, lat, 10);
        check_eq({tag, "_miss"}, int'(pick_miss), 0);
        check_eq({tag, "_row"}, int'(pick_row), r);
        check_eq({tag, "_col"}, int'(pick_col), c);
        check_eq({tag, "_box"}, int'(pick_box), b);
        check_eq({tag, "_value"}, int'(pick_value), cell_val(r, c));
    endtask

    task automatic miss_test(input string tag, input int x, input int y, input int sz);
        int lat;
        do_pick(x, y, sz, lat);
        check_eq({tag, "_lat"}, lat, 2);
        check_eq({tag, "_miss"}, int'(pick_miss), 1);
        check_eq({tag, "_rowcol"}, int'({pick_row, pick_col}), 0);
        check_eq({tag, "_boxval"}, int'({pick_box, pick_value}), 0);
    endtask

    initial begin
        int n;
        int lat;
        int busy_seen;

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                board[r][c] = 5'(cell_val(r, c));
        rst = 1'b1;
        is_game_on = 1'b1;
        board_size = 3'd3;
        mouse_xpos = '0;
        mouse_ypos = '0;
        mouse_left = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_valid", int'(pick_valid), 0);
        check_eq("reset_miss", int'(pick_miss), 0);
        check_eq("reset_outs", int'({pick_row, pick_col, pick_box, pick_value}), 0);

        // Main hit/miss geometry.
        hit_test("s3_hit", 523, 439, 3, 7, 5, 7);
        miss_test("s3_right_edge", 584, 400, 3);
        hit_test("s3_origin", 440, 312, 3, 0, 0, 0);
        miss_test("s3_left_edge", 439, 312, 3);
        hit_test("s4_corner", 639, 511, 4, 15, 15, 15);
        hit_test("s4_mid", 500, 400, 4, 9, 7, 9);
        hit_test("s2_origin", 495, 367, 2, 0, 0, 0);
        hit_test("s2_corner", 543, 415, 2, 3, 3, 3);
        miss_test("size0", 512, 384, 0);
        miss_test("size5", 512, 384, 5);

        // Game off: click is ignored.
        is_game_on = 1'b0;
        @(negedge clk);
        mouse_left = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_seen = 1;
        end
        check_eq("game_off_busy", busy_seen, 0);
        @(negedge clk);
        mouse_left = 1'b0;
        is_game_on = 1'b1;
        $display("[TB] click with game off, busy_seen=%0d", busy_seen);

        // Held button gives exactly one pick.
        @(negedge clk);
        mouse_xpos = 12'd523;
        mouse_ypos = 12'd439;
        board_size = 3'd3;
        mouse_left = 1'b1;
        count_valid(50, n);
        @(negedge clk);
        mouse_left = 1'b0;
        begin
            int n2;
            count_valid(10, n2);
            n += n2;
        end
        check_eq("hold50_count", n, 1);
        $display("[TB] held button 50 cycles, picks=%0d", n);

        // Second click at cycle 4 is dropped.
        @(negedge clk);
        mouse_xpos = 12'd523;
        mouse_ypos = 12'd439;
        mouse_left = 1'b1;
        @(posedge clk);              // cycle 0 sampled
        @(negedge clk);
        mouse_left = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);              // cycle 4
        mouse_left = 1'b1;
        count_valid(30, n);
        @(negedge clk);
        mouse_left = 1'b0;
        check_eq("reclick_count", n, 1);
        check_eq("reclick_row", int'(pick_row), 7);
        $display("[TB] second click while busy, picks=%0d", n);

        // Drop is_game_on in DIV: abort, results kept.
        @(negedge clk);
        mouse_xpos = 12'd639;
        mouse_ypos = 12'd511;
        board_size = 3'd4;
        mouse_left = 1'b1;
        repeat (3) @(posedge clk);   // now in DIV (cycle 3)
        @(negedge clk);
        is_game_on = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_busy", int'(busy), 0);
        count_valid(15, n);
        check_eq("abort_valid", n, 0);
        check_eq("abort_row_kept", int'(pick_row), 7);
        check_eq("abort_box_kept", int'(pick_box), 7);
        @(negedge clk);
        mouse_left = 1'b0;
        is_game_on = 1'b1;
        $display("[TB] abort in DIV, picks=%0d row=%0d", n, pick_row);

        // Reset in DIV with the button held through reset.
        @(negedge clk);
        mouse_xpos = 12'd523;
        mouse_ypos = 12'd439;
        board_size = 3'd3;
        mouse_left = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_valid", int'(pick_valid), 0);
        check_eq("rst_outs", int'({pick_miss, pick_row, pick_col, pick_box, pick_value}), 0);
        @(negedge clk);
        rst = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_seen = 1;
        end
        check_eq("held_thru_rst_busy", busy_seen, 0);
        @(negedge clk);
        mouse_left = 1'b0;
        $display("[TB] reset in DIV, held button busy_seen=%0d", busy_seen);

        hit_test("after_rst", 523, 439, 3, 7, 5, 7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
